// File: rtl/serial_tx.sv
// serial_tx: parallel-in, serial-out transmitter.
// Each word accepted on a valid/ready handshake is framed as a start bit (0),
// DATA_W data bits sent LSB first, and a stop bit (1). Every bit is held for
// CLKS_PER_BIT clock cycles.
//
// Ports:
//   clk       system clock, all logic on posedge
//   rst       synchronous active-high reset
//   tx_data   word to send, latched on the handshake edge
//   tx_valid  producer has a word on tx_data
//   tx_ready  block can accept a word (high only in IDLE)
//   tx_out    registered serial line, idles high
//   tx_busy   high for every cycle of a frame (START..STOP)
//   tx_done   one-cycle pulse on the last cycle of the stop bit
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t              state, state_n;
    logic [CW-1:0]       cyc, cyc_n;
    logic [BW-1:0]       bit_idx, bit_n;
    logic [DATA_W-1:0]   shreg, shreg_n;
    logic                out_q, out_n;
    logic                bit_end;

    assign bit_end = (cyc == CYC_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cyc     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            out_q   <= 1'b1;
        end else begin
            state   <= state_n;
            cyc     <= cyc_n;
            bit_idx <= bit_n;
            shreg   <= shreg_n;
            out_q   <= out_n;
        end
    end

    always_comb begin
        state_n = state;
        cyc_n   = cyc;
        bit_n   = bit_idx;
        shreg_n = shreg;
        case (state)
            IDLE: begin
                cyc_n = '0;
                bit_n = '0;
                // tx_ready is exactly "in IDLE", so tx_valid alone completes the handshake here
                if (tx_valid) begin
                    state_n = START;
                    shreg_n = tx_data;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    cyc_n   = '0;
                end else begin
                    cyc_n = cyc + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cyc_n = '0;
                    if (bit_idx == BIT_LAST) begin
                        state_n = STOP;
                        bit_n   = '0;
                    end else begin
                        bit_n   = bit_idx + 1'b1;
                        shreg_n = shreg >> 1;
                    end
                end else begin
                    cyc_n = cyc + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                    cyc_n   = '0;
                end else begin
                    cyc_n = cyc + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Line level is computed from the next state so tx_out can be a plain
        // register and still change on the same edge as the state.
        case (state_n)
            START:   out_n = 1'b0;
            DATA:    out_n = shreg_n[0];
            default: out_n = 1'b1;
        endcase
    end

    assign tx_out   = out_q;
    assign tx_ready = (state == IDLE);
    assign tx_busy  = (state != IDLE);
    assign tx_done  = (state == STOP) && bit_end;

endmodule

// File: tb/tb_serial_tx.sv
// Directed testbench for serial_tx: one instance at CLKS_PER_BIT=4 and one at
// CLKS_PER_BIT=1, both DATA_W=8, sharing clock and reset.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready, tx_out, tx_busy, tx_done;
    logic [7:0] d1_data;
    logic       d1_valid, d1_ready, d1_out, d1_busy, d1_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_out(tx_out), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .tx_data(d1_data), .tx_valid(d1_valid),
        .tx_ready(d1_ready), .tx_out(d1_out), .tx_busy(d1_busy), .tx_done(d1_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level at frame cycle c for the CLKS_PER_BIT=4 instance.
    function automatic logic exp_line(input logic [7:0] w, input int c);
        if (c < 4)   return 1'b0;
        if (c >= 36) return 1'b1;
        return w[c/4-1];
    endfunction

    task automatic check_idle(input string tag);
        check({tag, " out"},   tx_out,   1);
        check({tag, " ready"}, tx_ready, 1);
        check({tag, " busy"},  tx_busy,  0);
        check({tag, " done"},  tx_done,  0);
    endtask

    // Present w and return at frame cycle 0 (one edge after the handshake).
    task automatic send(input logic [7:0] w, input string tag);
        int n = 0;
        tx_data  = w;
        tx_valid = 1'b1;
        while (!tx_ready && n < 200) begin
            tick();
            n++;
        end
        check({tag, " wait ready"}, tx_ready, 1);
        tick();
    endtask

    // Check all 40 frame cycles, decoding mid-bit like a receiver would.
    // Returns on the last (stop) cycle of the frame.
    task automatic frame(input logic [7:0] w, input string tag,
                         input int chg_cyc, input logic [7:0] chg_data);
        logic [7:0] rx = '0;
        for (int c = 0; c < 40; c++) begin
            if (c == chg_cyc) tx_data = chg_data;
            check($sformatf("%s c%0d out", tag, c),   tx_out,   exp_line(w, c));
            check($sformatf("%s c%0d busy", tag, c),  tx_busy,  1);
            check($sformatf("%s c%0d ready", tag, c), tx_ready, 0);
            check($sformatf("%s c%0d done", tag, c),  tx_done,  (c == 39));
            if (c >= 4 && c < 36 && (c % 4) == 2) rx[c/4-1] = tx_out;
            if (c < 39) tick();
        end
        check({tag, " rx word"}, rx, w);
    endtask

    initial begin
        logic [9:0] exp1;

        // Reset with valid asserted: nothing may start.
        rst = 1'b1; tx_valid = 1'b1; tx_data = 8'hA5;
        d1_valid = 1'b1; d1_data = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle($sformatf("rst%0d", i));
            check($sformatf("rst%0d d1 busy", i), d1_busy, 0);
            check($sformatf("rst%0d d1 out", i),  d1_out,  1);
        end
        rst = 1'b0; tx_valid = 1'b0; d1_valid = 1'b0;
        tick();
        check_idle("post rst");

        // Single frame 0xA5.
        send(8'hA5, "a5");
        tx_valid = 1'b0;
        frame(8'hA5, "a5", -1, 8'h00);
        tick();
        check_idle("a5 after");

        // Back-to-back with tx_valid held high: 0x00 then 0xFF.
        send(8'h00, "b2b0");
        frame(8'h00, "b2b0", 0, 8'hFF);
        tick();
        check_idle("b2b gap");
        tick();
        tx_valid = 1'b0;
        frame(8'hFF, "b2b1", -1, 8'h00);
        tick();
        check_idle("b2b after");

        // Data change mid-frame is ignored; the new word waits for IDLE.
        send(8'h3C, "chg0");
        frame(8'h3C, "chg0", 10, 8'hC3);
        tick();
        check("chg gap ready", tx_ready, 1);
        check("chg gap out",   tx_out,   1);
        tick();
        tx_valid = 1'b0;
        frame(8'hC3, "chg1", -1, 8'h00);
        tick();
        check_idle("chg after");

        // Reset at cycle 17 of a 0x55 frame, with a handshake offered meanwhile.
        send(8'h55, "rmid");
        tx_valid = 1'b0;
        repeat (17) tick();
        check("rmid c17 out",  tx_out,  0);
        check("rmid c17 busy", tx_busy, 1);
        rst = 1'b1; tx_valid = 1'b1; tx_data = 8'h81;
        tick();
        check_idle("rmid rst");
        rst = 1'b0; tx_valid = 1'b0;
        tick();
        check_idle("rmid released");
        send(8'h81, "r81");
        tx_valid = 1'b0;
        frame(8'h81, "r81", -1, 8'h00);
        tick();
        check_idle("r81 after");

        // CLKS_PER_BIT=1 instance, word 0x01: line 0,1,0,0,0,0,0,0,0,1.
        exp1 = 10'b10_0000_0010;
        d1_data = 8'h01; d1_valid = 1'b1;
        check("d1 ready", d1_ready, 1);
        tick();
        d1_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            check($sformatf("d1 c%0d out", c),  d1_out,  exp1[c]);
            check($sformatf("d1 c%0d busy", c), d1_busy, 1);
            check($sformatf("d1 c%0d done", c), d1_done, (c == 9));
            tick();
        end
        check("d1 after busy",  d1_busy,  0);
        check("d1 after ready", d1_ready, 1);
        check("d1 after out",   d1_out,   1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Parallel-in, serial-out transmitter; the driving end of the single-bit serial link that the team's D-type capture stages sample.
- Accepts one word per valid/ready handshake and frames it as: start bit (0), DATA_W data bits LSB first, stop bit (1).
- Each bit is held for CLKS_PER_BIT clock cycles.
- Sits between a parallel producer (register file, FIFO) and the serial line.

Parameters:
DATA_W, 8, width of transmitted word
CLKS_PER_BIT, 4, clock cycles per serial bit; legal range >= 1

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous active-high reset
tx_data  input  DATA_W  word to send; sampled only on handshake
tx_valid  input  1  producer has a word on tx_data
tx_ready  output  1  block can accept a word (high only in IDLE)
tx_out  output  1  serial line; idles high
tx_busy  output  1  high while a frame is in progress (START..STOP)
tx_done  output  1  one-cycle pulse on the final cycle of the stop bit

Behaviour:
- One clock, clk. Reset is rst: synchronous and active-high, sampled on posedge clk.
- Reset values: state=IDLE, tx_out=1, tx_ready=1, tx_busy=0, tx_done=0. Bit counter, cycle counter and shift register are cleared.
- States and transitions:
  - IDLE: go to START when tx_valid & tx_ready.
  - START: go to DATA after CLKS_PER_BIT cycles.
  - DATA: go to STOP after DATA_W bits.
  - STOP: go to IDLE after CLKS_PER_BIT cycles.
- Handshake:
  - Transfer occurs on the posedge where tx_valid=1 and tx_ready=1.
  - tx_data is latched into the shift register on that edge.
  - tx_ready = (state==IDLE). It is decoded from registered state; there is no combinational path from tx_valid.
- Latency: tx_out falls to 0 on the cycle immediately after the handshake edge.
- Line timing, with start at cycle 0 of the frame:
  - Start bit: tx_out=0 for cycles 0..CLKS_PER_BIT-1.
  - Data bit k (k=0..DATA_W-1): held for cycles (k+1)*CLKS_PER_BIT .. (k+2)*CLKS_PER_BIT-1.
  - Stop bit: tx_out=1 for the final CLKS_PER_BIT cycles.
  - Total frame length: (DATA_W+2)*CLKS_PER_BIT cycles.
- tx_busy is 1 for exactly the frame cycles and 0 in IDLE.
- tx_done is 1 only on the last cycle of STOP. The following cycle, state=IDLE and tx_ready=1.
- Back-to-back frames:
  - The producer may hold tx_valid high continuously.
  - The next handshake happens in the single IDLE cycle after tx_done.
  - Minimum inter-frame gap is therefore 1 cycle of tx_out=1, which is an extended stop.
- Input stability: tx_data and tx_valid changes during a frame are ignored. The frame transmits the latched word only.
- CLKS_PER_BIT=1: every bit lasts one cycle and the frame is DATA_W+2 cycles. tx_done coincides with the single stop cycle.
- Cycle counter: counts 0..CLKS_PER_BIT-1 and wraps. Width is clog2(CLKS_PER_BIT), minimum 1.
- Bit counter: counts 0..DATA_W-1 in DATA only.
- Reset mid-frame:
  - Aborts the frame. On the next cycle tx_out=1, state=IDLE, tx_ready=1.
  - No tx_done pulse is generated.
  - Any handshake presented in the same cycle as rst is not accepted.
- tx_out is registered. There are no glitches and no combinational path from inputs.

Test Plan:
- Reset: assert rst for 3 cycles with tx_valid=1 -> tx_out=1, tx_ready=1, tx_busy=0, tx_done=0 throughout; no frame starts while rst=1.
- Single frame (DATA_W=8, CLKS_PER_BIT=4): send 0xA5 -> tx_out is 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles. tx_busy is high for 40 cycles. tx_done pulses on cycle 39 only.
- Back-to-back: tx_valid held high with 0x00 then 0xFF -> second start bit begins exactly 2 cycles after tx_done of the first frame. tx_out stays 1 in the gap cycle. Both words are decoded correctly by a reference receiver.
- Input change mid-frame: send 0x3C, change tx_data to 0xC3 at cycle 10 -> line carries 0x3C. The second word is accepted only at the next IDLE.
- Reset mid-frame: assert rst at cycle 17 of a 0x55 frame -> tx_out=1 the next cycle, no tx_done pulse, tx_ready=1 after rst deasserts. A new frame of 0x81 then transmits correctly.
- Minimum divider (CLKS_PER_BIT=1, DATA_W=8): send 0x01 -> 10-cycle frame on the line: 0,1,0,0,0,0,0,0,0,1. tx_done pulses on the 10th frame cycle.
